// File: rtl/pwm_decoder.sv
// pwm_decoder: measures high time and period of a sampled asynchronous PWM waveform.
// Latency: meas_valid strobes SYNC_STAGES+2 clk (+/-1) after the pwm_in rising transition.
// Backpressure: none; each measurement is presented for one cycle and must be taken then.
//
// Ports:
//   clk, rst     single clock, asynchronous active-high reset
//   pwm_in       asynchronous PWM input
//   high_time    clk cycles from a rising edge to the following falling edge
//   period       clk cycles between two successive rising edges
//   meas_valid   one-cycle strobe when high_time/period update
//   stuck        no rising edge within 2^CNT_W-1 cycles while measuring
//   stuck_level  synchronised pwm_in level captured when stuck was set
//
// SYNC_STAGES must be 2 or 3.
module pwm_decoder #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SEEK      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hold_high;

  logic timeout;
  logic capture_high;
  logic publish;

  // Input synchroniser and edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // cnt holds (cycles since last rise); a rise always reloads 1 so the
  // value seen on the next rise equals the rise-to-rise distance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if (state != SEEK && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Saturation ends the measurement; it takes priority over any edge in the
  // same cycle so a saturated count is never published.
  assign timeout = (state != SEEK) && (cnt == CNT_MAX);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEEK;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      SEEK: begin
        if (rise) state_nxt = MEAS_HIGH;
      end
      MEAS_HIGH: begin
        if (timeout)   state_nxt = SEEK;
        else if (fall) state_nxt = MEAS_LOW;
      end
      MEAS_LOW: begin
        if (timeout)   state_nxt = SEEK;
        else if (rise) state_nxt = MEAS_HIGH;
      end
      default: state_nxt = SEEK;
    endcase
  end

  // FSM: outputs (datapath controls)
  always_comb begin
    capture_high = 1'b0;
    publish      = 1'b0;
    case (state)
      MEAS_HIGH: capture_high = fall & ~timeout;
      MEAS_LOW:  publish      = rise & ~timeout;
      default: begin
        capture_high = 1'b0;
        publish      = 1'b0;
      end
    endcase
  end

  // Measurement registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_high   <= '0;
      high_time   <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= publish;
      if (capture_high) begin
        hold_high <= cnt;
      end
      if (publish) begin
        high_time <= hold_high;
        period    <= cnt;
      end
      // stuck is cleared only by a complete measurement, not by the first rise
      if (timeout) begin
        stuck       <= 1'b1;
        stuck_level <= s;
      end else if (publish) begin
        stuck <= 1'b0;
      end
    end
  end

endmodule
